// File: rtl/imem_loader_pkg.sv
// Shared types and width constants for the instruction-memory loader.
// Optional checksum support is selected with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int LEN_W  = 16;
    localparam int BIDX_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_CHK   = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian byte-to-word assembler: lane chosen by a 2-bit byte counter,
// word_valid flags the accept of the fourth byte of a word.
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic [7:0]  din,
    input  logic        accept,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [BIDX_W-1:0] b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b    <= '0;
            word <= '0;
        end else if (clr) begin
            b    <= '0;
            word <= '0;
        end else if (accept) begin
            word[{b, 3'b000} +: 8] <= din;
            b                      <= b + 2'd1;
        end
    end

    assign word_valid = accept && (b == '1);

endmodule

// File: rtl/imem_loader.sv
// Serial instruction-memory loader: length header, LE words, optional checksum
// byte (IMEM_LOADER_CHECKSUM_EN). Holds the core in reset until the load ends.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | after reset, waiting for start
// LEN0     | accept low byte of word count
// LEN1     | accept high byte of word count
// DATA     | accept data bytes into the assembler
// WRITE    | one-cycle memory write, bump word counter
// CHK      | accept checksum byte (checksum build only)
// DONE     | load complete, core released
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH_W   = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam logic [32:0] DEPTH_WORDS = 33'd1 << DEPTH_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t ST_TAIL = ST_CHK;
`else
    localparam state_t ST_TAIL = ST_DONE;
`endif

    state_t           state, next_state;
    logic [7:0]       len_lo;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] k;
    logic             start_ok;
    logic             accept;
    logic             asm_accept;
    logic             word_valid;
    logic [31:0]      asm_word;
    logic             ovf;
    logic             last_word;

    assign start_ok   = start && (state == ST_IDLE || state == ST_DONE);
    assign accept     = in_valid && in_ready;
    assign asm_accept = accept && (state == ST_DATA);
    assign ovf        = {17'b0, k} >= DEPTH_WORDS;
    assign last_word  = (k + 16'd1) == len;

    byte_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clr        (start_ok),
        .din        (in_data),
        .accept     (asm_accept),
        .word       (asm_word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_LEN0;
            ST_LEN0:  if (accept) next_state = ST_LEN1;
            ST_LEN1: begin
                if (accept) begin
                    if ({in_data, len_lo} == 16'd0) next_state = ST_TAIL;
                    else                            next_state = ST_DATA;
                end
            end
            ST_DATA:  if (word_valid) next_state = ST_WRITE;
            ST_WRITE: next_state = last_word ? ST_TAIL : ST_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK:   if (accept) next_state = ST_DONE;
`endif
            ST_DONE:  if (start) next_state = ST_LEN0;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_lo <= '0;
            len    <= '0;
        end else begin
            if (state == ST_LEN0 && accept) len_lo <= in_data;
            if (state == ST_LEN1 && accept) len    <= {in_data, len_lo};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                k <= '0;
        else if (start_ok)         k <= '0;
        else if (state == ST_WRITE) k <= k + 16'd1;
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] xsum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          xsum <= '0;
        else if (start_ok)   xsum <= '0;
        else if (asm_accept) xsum <= xsum ^ in_data;
    end

    // Overflowed words are still XORed: the checksum covers the whole stream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                        err <= 1'b0;
        else if (start_ok)                                 err <= 1'b0;
        else if (state == ST_WRITE && ovf)                 err <= 1'b1;
        else if (state == ST_CHK && accept && in_data != xsum) err <= 1'b1;
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                        err <= 1'b0;
        else if (start_ok)                 err <= 1'b0;
        else if (state == ST_WRITE && ovf) err <= 1'b1;
    end
`endif

    assign in_ready   = (state == ST_LEN0) || (state == ST_LEN1) ||
                        (state == ST_DATA) || (state == ST_CHK);
    assign imem_we    = (state == ST_WRITE) && !ovf;
    assign imem_addr  = BASE_ADDR + {14'b0, k, 2'b00};
    assign imem_wdata = asm_word;
    assign cpu_hold   = (state != ST_DONE);
    assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader (DEPTH_W=2 so overflow is reachable);
// adapts to IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    wr_t expq[$];
    int  total = 0;
    int  bad   = 0;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH_W(2), .BASE_ADDR(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (reset === 1'b1 && imem_we === 1'b1) begin
            chk("ready_during_write", {31'b0, in_ready}, 32'd0);
            if (expq.size() == 0) begin
                chk("unexpected_write", imem_addr, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = expq.pop_front();
                chk("write_addr", imem_addr, e.a);
                chk("write_data", imem_wdata, e.d);
            end
        end
    end

    function automatic logic [7:0] data_xor(input logic [7:0] s[$]);
        logic [7:0] x = 8'h00;
        for (int i = 2; i < s.size(); i++) x ^= s[i];
        return x;
    endfunction

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        expq.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bp);
        int n = 0;
        if (bp) begin
            while ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk("ready_timeout", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // mid_start >= 0 pulses start (must be ignored) after that byte index.
    task automatic load(input logic [7:0] s[$], input bit bp, input int mid_start);
        pulse_start();
        for (int i = 0; i < s.size(); i++) begin
            send_byte(s[i], bp);
            if (i == mid_start) pulse_start();
        end
    endtask

    task automatic wait_done(input string name, input logic exp_err);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, {31'b0, done}, 32'd1);
        chk({name, "_hold"}, {31'b0, cpu_hold}, 32'd0);
        chk({name, "_ready"}, {31'b0, in_ready}, 32'd0);
        chk({name, "_err"}, {31'b0, err}, {31'b0, exp_err});
        chk({name, "_pending"}, expq.size(), 32'd0);
    endtask

    task automatic check_reset_values(input string name);
        chk({name, "_ready"}, {31'b0, in_ready}, 32'd0);
        chk({name, "_we"}, {31'b0, imem_we}, 32'd0);
        chk({name, "_addr"}, imem_addr, 32'h0000_0000);
        chk({name, "_wdata"}, imem_wdata, 32'd0);
        chk({name, "_hold"}, {31'b0, cpu_hold}, 32'd1);
        chk({name, "_done"}, {31'b0, done}, 32'd0);
        chk({name, "_err"}, {31'b0, err}, 32'd0);
    endtask

    initial begin
        logic [7:0] s2[$];
        logic [7:0] sz[$];
        logic [7:0] so[$];
        logic [7:0] sp[$];

        reset    = 1'b0;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        #1;
        check_reset_values("por");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        s2 = '{8'h02, 8'h00, 8'h93, 8'h83, 8'h71, 8'hFF, 8'h33, 8'hE2, 8'h23, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s2.push_back(data_xor(s2));
`endif

        // two-word load with an ignored start pulse in the middle of a word
        push_wr(32'h0, 32'hFF71_8393);
        push_wr(32'h4, 32'h0023_E233);
        load(s2, 1'b0, 3);
        wait_done("two_word", 1'b0);

        // same stream under random valid gaps
        push_wr(32'h0, 32'hFF71_8393);
        push_wr(32'h4, 32'h0023_E233);
        load(s2, 1'b1, -1);
        wait_done("backpressure", 1'b0);

        sz = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        sz.push_back(8'h00);
`endif
        load(sz, 1'b0, -1);
        wait_done("zero_len", 1'b0);

        // reset in the middle of a word
        pulse_start();
        sp = '{8'h02, 8'h00, 8'h93, 8'h83};
        for (int i = 0; i < sp.size(); i++) send_byte(sp[i], 1'b0);
        reset = 1'b0;
        #1;
        check_reset_values("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("after_reset_ready", {31'b0, in_ready}, 32'd0);
        chk("after_reset_hold", {31'b0, cpu_hold}, 32'd1);

        // N=5 into a 4-word memory: bytes run 0x00..0x13
        so = '{8'h05, 8'h00};
        for (int w = 0; w < 5; w++) begin
            for (int j = 0; j < 4; j++) so.push_back(8'(w * 4 + j));
            if (w < 4) push_wr(32'(w * 4),
                               {8'(w * 4 + 3), 8'(w * 4 + 2), 8'(w * 4 + 1), 8'(w * 4)});
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        so.push_back(data_xor(so));
`endif
        load(so, 1'b0, -1);
        wait_done("overflow", 1'b1);

        pulse_start();
        chk("restart_err", {31'b0, err}, 32'd0);
        chk("restart_done", {31'b0, done}, 32'd0);
        chk("restart_hold", {31'b0, cpu_hold}, 32'd1);
        chk("restart_ready", {31'b0, in_ready}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

`ifdef IMEM_LOADER_CHECKSUM_EN
        sp = '{8'h02, 8'h00, 8'h93, 8'h83, 8'h71, 8'hFF, 8'h33, 8'hE2, 8'h23, 8'h00, 8'h00};
        push_wr(32'h0, 32'hFF71_8393);
        push_wr(32'h4, 32'h0023_E233);
        load(sp, 1'b0, -1);
        wait_done("chk_err", 1'b1);
        pulse_start();
        chk("chk_restart_err", {31'b0, err}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("final_pending", expq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
